// File: rtl/bsg_manycore_edge_endpoint_pkg.sv
// Shared definitions for the manycore edge endpoint.
// Orig packet layout, MSB->LSB: {op[1:0], addr, data, y_cord, x_cord}.
package bsg_manycore_edge_endpoint_pkg;

  localparam logic [1:0] EpOpLoad   = 2'b00;
  localparam logic [1:0] EpOpStore  = 2'b01;
  localparam logic [1:0] EpOpConfig = 2'b10;

  localparam logic [0:0] TxEmpty = 1'b0;
  localparam logic [0:0] TxFull  = 1'b1;

  function automatic int unsigned orig_packet_width(int unsigned addr_w, int unsigned data_w,
                                                    int unsigned x_w, int unsigned y_w);
    return 2 + addr_w + data_w + x_w + y_w;
  endfunction

  function automatic int unsigned credit_width(int unsigned max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_edge_endpoint_rx_fifo.sv
// Ready-valid rx buffer that drops packets not addressed to this endpoint.
// Output is registered: an enqueued packet is visible the cycle after enqueue.
module bsg_manycore_edge_endpoint_rx_fifo #(
  parameter int unsigned width_p        = 26,
  parameter int unsigned els_p          = 2,
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [15:0]               drop_count_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned CntW = $clog2(els_p + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(els_p - 1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(els_p);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [width_p-1:0] mem_q [els_p];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [15:0]        drop_q, drop_d;
  logic               enq, match, wr, rd;

  always_comb begin
    ready_o = (count_q != CntFull);
    v_o     = (count_q != '0);
    data_o  = mem_q[rd_ptr_q];
    enq     = v_i & ready_o;
    match   = (data_i[x_cord_width_p-1:0] == my_x_i) &&
              (data_i[x_cord_width_p +: y_cord_width_p] == my_y_i);
    wr      = enq & match;
    rd      = yumi_i & v_o;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (wr) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    if (rd) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
    if (wr && !rd) count_d = count_q + CntOne;
    else if (rd && !wr) count_d = count_q - CntOne;
    if (enq && !match && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset; emptiness is carried by the count.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= data_i;
  end

  assign drop_count_o = drop_q;

endmodule

// File: rtl/bsg_manycore_edge_endpoint.sv
// Off-array edge endpoint: credit-limited tx injection of host requests and
// coordinate-filtered, buffered rx of packets leaving the array.
module bsg_manycore_edge_endpoint
  import bsg_manycore_edge_endpoint_pkg::*;
#(
  parameter int unsigned addr_width_p         = 32,
  parameter int unsigned data_width_p         = 32,
  parameter int unsigned x_cord_width_p       = 4,
  parameter int unsigned y_cord_width_p       = 4,
  parameter int unsigned max_out_credits_p    = 4,
  parameter int unsigned rx_fifo_els_p        = 2,
  parameter int unsigned orig_packet_width_lp =
      orig_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
  parameter int unsigned credit_width_lp      = credit_width(max_out_credits_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [x_cord_width_p-1:0]       my_x_i,
  input  logic [y_cord_width_p-1:0]       my_y_i,
  input  logic                            host_v_i,
  input  logic [1:0]                      host_op_i,
  input  logic [addr_width_p-1:0]         host_addr_i,
  input  logic [data_width_p-1:0]         host_data_i,
  input  logic [x_cord_width_p-1:0]       host_x_i,
  input  logic [y_cord_width_p-1:0]       host_y_i,
  output logic                            host_ready_o,
  output logic [orig_packet_width_lp-1:0] link_data_o,
  output logic                            link_v_o,
  input  logic                            link_ready_i,
  input  logic [orig_packet_width_lp-1:0] link_data_i,
  input  logic                            link_v_i,
  output logic                            link_ready_o,
  output logic                            rx_v_o,
  output logic [1:0]                      rx_op_o,
  output logic [addr_width_p-1:0]         rx_addr_o,
  output logic [data_width_p-1:0]         rx_data_o,
  output logic [x_cord_width_p-1:0]       rx_x_o,
  output logic [y_cord_width_p-1:0]       rx_y_o,
  input  logic                            rx_yumi_i,
  input  logic                            credit_i,
  output logic [credit_width_lp-1:0]      out_credits_o,
  output logic [15:0]                     drop_count_o
);

  localparam int unsigned XW = x_cord_width_p;
  localparam int unsigned YW = y_cord_width_p;
  localparam int unsigned DW = data_width_p;
  localparam int unsigned AW = addr_width_p;
  localparam logic [credit_width_lp-1:0] CredMax = credit_width_lp'(max_out_credits_p);
  localparam logic [credit_width_lp-1:0] CredOne = credit_width_lp'(1);

  logic [0:0]                      tx_state_q, tx_state_d;
  logic [orig_packet_width_lp-1:0] tx_pkt_q, tx_pkt_d;
  logic [credit_width_lp-1:0]      credits_q, credits_d;
  logic                            have_credit, host_accept;
  logic [orig_packet_width_lp-1:0] rx_pkt;

  always_comb begin
    have_credit  = (credits_q != '0);
    host_ready_o = 1'b0;
    case (tx_state_q)
      TxEmpty: host_ready_o = have_credit;
      // Reload only when the held packet leaves this cycle.
      TxFull:  host_ready_o = link_ready_i & have_credit;
      default: host_ready_o = 1'b0;
    endcase
    if (reset_i) host_ready_o = 1'b0;
    host_accept = host_v_i & host_ready_o;

    tx_state_d = tx_state_q;
    tx_pkt_d   = tx_pkt_q;
    if (host_accept) begin
      tx_pkt_d   = {host_op_i, host_addr_i, host_data_i, host_y_i, host_x_i};
      tx_state_d = TxFull;
    end else if (tx_state_q == TxFull && link_ready_i) begin
      tx_state_d = TxEmpty;
    end

    credits_d = credits_q;
    if (host_accept && !credit_i) credits_d = credits_q - CredOne;
    else if (credit_i && !host_accept && credits_q != CredMax) credits_d = credits_q + CredOne;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q <= TxEmpty;
      tx_pkt_q   <= '0;
      credits_q  <= CredMax;
    end else begin
      tx_state_q <= tx_state_d;
      tx_pkt_q   <= tx_pkt_d;
      credits_q  <= credits_d;
    end
  end

  assign link_v_o      = (tx_state_q == TxFull);
  assign link_data_o   = tx_pkt_q;
  assign out_credits_o = credits_q;

  bsg_manycore_edge_endpoint_rx_fifo #(
    .width_p        (orig_packet_width_lp),
    .els_p          (rx_fifo_els_p),
    .x_cord_width_p (x_cord_width_p),
    .y_cord_width_p (y_cord_width_p)
  ) u_rx_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .my_x_i       (my_x_i),
    .my_y_i       (my_y_i),
    .v_i          (link_v_i),
    .data_i       (link_data_i),
    .ready_o      (link_ready_o),
    .v_o          (rx_v_o),
    .data_o       (rx_pkt),
    .yumi_i       (rx_yumi_i),
    .drop_count_o (drop_count_o)
  );

  assign rx_x_o    = rx_pkt[XW-1:0];
  assign rx_y_o    = rx_pkt[XW +: YW];
  assign rx_data_o = rx_pkt[XW+YW +: DW];
  assign rx_addr_o = rx_pkt[XW+YW+DW +: AW];
  assign rx_op_o   = rx_pkt[orig_packet_width_lp-1 -: 2];

  a_yumi_without_v: assert property (@(posedge clk_i) disable iff (reset_i)
      !(rx_yumi_i && !rx_v_o))
    else $error("rx_yumi_i asserted with no rx packet valid");

  a_credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(credit_i && !host_accept && credits_q == CredMax))
    else $error("credit returned while counter already at max");

  a_link_v_known: assert property (@(posedge clk_i) disable iff (reset_i)
      !$isunknown(link_v_i))
    else $error("link_v_i is unknown");

endmodule

// File: tb/tb_bsg_manycore_edge_endpoint.sv
// Directed, scoreboarded bench for bsg_manycore_edge_endpoint.
module tb_bsg_manycore_edge_endpoint;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned XW = 4;
  localparam int unsigned YW = 4;
  localparam int unsigned PktW = 2 + AW + DW + XW + YW;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [XW-1:0]   my_x_i;
  logic [YW-1:0]   my_y_i;
  logic            host_v_i;
  logic [1:0]      host_op_i;
  logic [AW-1:0]   host_addr_i;
  logic [DW-1:0]   host_data_i;
  logic [XW-1:0]   host_x_i;
  logic [YW-1:0]   host_y_i;
  logic            host_ready_o;
  logic [PktW-1:0] link_data_o;
  logic            link_v_o;
  logic            link_ready_i;
  logic [PktW-1:0] link_data_i;
  logic            link_v_i;
  logic            link_ready_o;
  logic            rx_v_o;
  logic [1:0]      rx_op_o;
  logic [AW-1:0]   rx_addr_o;
  logic [DW-1:0]   rx_data_o;
  logic [XW-1:0]   rx_x_o;
  logic [YW-1:0]   rx_y_o;
  logic            rx_yumi_i;
  logic            credit_i;
  logic [2:0]      out_credits_o;
  logic [15:0]     drop_count_o;

  int checks = 0;
  int failures = 0;
  int tx_count = 0;
  logic [15:0] drop_exp = '0;
  logic [PktW-1:0] tx_q[$];
  logic [PktW-1:0] rx_q[$];
  logic [PktW-1:0] exp_pkt;

  always #5 clk_i = ~clk_i;

  bsg_manycore_edge_endpoint #(
    .addr_width_p      (AW),
    .data_width_p      (DW),
    .x_cord_width_p    (XW),
    .y_cord_width_p    (YW),
    .max_out_credits_p (4),
    .rx_fifo_els_p     (2)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .my_x_i        (my_x_i),
    .my_y_i        (my_y_i),
    .host_v_i      (host_v_i),
    .host_op_i     (host_op_i),
    .host_addr_i   (host_addr_i),
    .host_data_i   (host_data_i),
    .host_x_i      (host_x_i),
    .host_y_i      (host_y_i),
    .host_ready_o  (host_ready_o),
    .link_data_o   (link_data_o),
    .link_v_o      (link_v_o),
    .link_ready_i  (link_ready_i),
    .link_data_i   (link_data_i),
    .link_v_i      (link_v_i),
    .link_ready_o  (link_ready_o),
    .rx_v_o        (rx_v_o),
    .rx_op_o       (rx_op_o),
    .rx_addr_o     (rx_addr_o),
    .rx_data_o     (rx_data_o),
    .rx_x_o        (rx_x_o),
    .rx_y_o        (rx_y_o),
    .rx_yumi_i     (rx_yumi_i),
    .credit_i      (credit_i),
    .out_credits_o (out_credits_o),
    .drop_count_o  (drop_count_o)
  );

  function automatic logic [PktW-1:0] pack(logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d,
                                           logic [YW-1:0] y, logic [XW-1:0] x);
    return {op, a, d, y, x};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_req(logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
    host_v_i    = 1'b1;
    host_op_i   = op;
    host_addr_i = a;
    host_data_i = d;
    host_x_i    = 4'd1;
    host_y_i    = 4'd1;
  endtask

  task automatic link_send(logic [XW-1:0] x, logic [YW-1:0] y, logic [DW-1:0] d);
    link_v_i    = 1'b1;
    link_data_i = pack(2'b01, 8'hA0, d, y, x);
  endtask

  // Sample at the falling edge, update the scoreboard, then step past the rising edge.
  task automatic cycle();
    @(negedge clk_i);
    if (link_v_o && link_ready_i) begin
      check("tx_queue_nonempty", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) check("tx_pkt", 32'(link_data_o), 32'(tx_q.pop_front()));
      tx_count++;
    end
    if (rx_v_o && rx_yumi_i) begin
      check("rx_queue_nonempty", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0)
        check("rx_pkt", 32'({rx_op_o, rx_addr_o, rx_data_o, rx_y_o, rx_x_o}),
              32'(rx_q.pop_front()));
    end
    if (host_v_i && host_ready_o)
      tx_q.push_back(pack(host_op_i, host_addr_i, host_data_i, host_y_i, host_x_i));
    if (link_v_i && link_ready_o) begin
      if (link_data_i[XW-1:0] == my_x_i && link_data_i[XW +: YW] == my_y_i)
        rx_q.push_back(link_data_i);
      else if (drop_exp != 16'hFFFF)
        drop_exp = drop_exp + 16'd1;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    my_x_i = 4'd2;
    my_y_i = 4'd0;
    host_v_i = 1'b0;
    host_op_i = '0;
    host_addr_i = '0;
    host_data_i = '0;
    host_x_i = '0;
    host_y_i = '0;
    link_ready_i = 1'b1;
    link_data_i = '0;
    link_v_i = 1'b0;
    rx_yumi_i = 1'b0;
    credit_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_link_v", 32'(link_v_o), 32'd0);
    check("rst_rx_v", 32'(rx_v_o), 32'd0);
    check("rst_host_ready", 32'(host_ready_o), 32'd0);
    check("rst_credits", 32'(out_credits_o), 32'd4);
    check("rst_drop", 32'(drop_count_o), 32'd0);
    reset_i = 1'b0;
    #1;
    check("post_rst_host_ready", 32'(host_ready_o), 32'd1);

    // Four back-to-back packets exhaust the credits
    for (int i = 0; i < 4; i++) begin
      host_req(2'b01, 8'(8'h10 + i), 8'(8'hC0 + i));
      #1;
      check("burst_host_ready", 32'(host_ready_o), 32'd1);
      cycle();
    end
    host_req(2'b01, 8'h14, 8'hC4);
    #1;
    check("no_credit_host_ready", 32'(host_ready_o), 32'd0);
    check("burst_link_v", 32'(link_v_o), 32'd1);
    cycle();
    host_v_i = 1'b0;
    check("burst_tx_count", 32'(tx_count), 32'd4);
    check("burst_credits", 32'(out_credits_o), 32'd0);
    check("burst_link_v_done", 32'(link_v_o), 32'd0);
    credit_i = 1'b1;
    cycle();
    credit_i = 1'b0;
    #1;
    check("credit_ret_host_ready", 32'(host_ready_o), 32'd1);
    check("credit_ret_count", 32'(out_credits_o), 32'd1);

    // Accept and credit return together at credits=1, then stall the link
    link_ready_i = 1'b0;
    host_req(2'b10, 8'h20, 8'h55);
    credit_i = 1'b1;
    cycle();
    credit_i = 1'b0;
    host_req(2'b10, 8'h21, 8'h56);
    #1;
    check("same_cycle_credits", 32'(out_credits_o), 32'd1);
    check("stall_link_v", 32'(link_v_o), 32'd1);
    exp_pkt = pack(2'b10, 8'h20, 8'h55, 4'd1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_host_ready", 32'(host_ready_o), 32'd0);
      check("stall_link_data", 32'(link_data_o), 32'(exp_pkt));
      cycle();
    end
    host_v_i = 1'b0;
    link_ready_i = 1'b1;
    cycle();
    #1;
    check("stall_release_link_v", 32'(link_v_o), 32'd0);
    check("stall_tx_count", 32'(tx_count), 32'd5);
    cycle();
    check("stall_no_dup", 32'(tx_count), 32'd5);
    credit_i = 1'b1;
    repeat (3) cycle();
    credit_i = 1'b0;
    check("credits_refilled", 32'(out_credits_o), 32'd4);

    // Rx filtering: (2,0) kept, (3,0) dropped, (2,0) kept -> FIFO full
    link_send(4'd2, 4'd0, 8'h01);
    cycle();
    link_send(4'd3, 4'd0, 8'h02);
    #1;
    check("rx_ready_1", 32'(link_ready_o), 32'd1);
    cycle();
    link_send(4'd2, 4'd0, 8'h03);
    #1;
    check("rx_ready_2", 32'(link_ready_o), 32'd1);
    cycle();
    link_v_i = 1'b0;
    #1;
    check("rx_full_ready", 32'(link_ready_o), 32'd0);
    check("rx_full_v", 32'(rx_v_o), 32'd1);
    check("rx_drop_1", 32'(drop_count_o), 32'd1);
    // Enqueue attempt plus yumi while full: still not ready
    link_send(4'd2, 4'd0, 8'h04);
    rx_yumi_i = 1'b1;
    #1;
    check("rx_full_yumi_ready", 32'(link_ready_o), 32'd0);
    cycle();
    #1;
    check("rx_after_yumi_ready", 32'(link_ready_o), 32'd1);
    cycle();

    // Stream ten packets through, some misrouted, exercising pointer wrap
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) link_send(4'd5, 4'd1, 8'(8'h40 + i));
      else link_send(4'd2, 4'd0, 8'(8'h40 + i));
      rx_yumi_i = rx_v_o;
      cycle();
    end
    link_v_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_yumi_i = rx_v_o;
      cycle();
    end
    rx_yumi_i = 1'b0;
    check("rx_drained", 32'(rx_q.size()), 32'd0);
    check("rx_empty_v", 32'(rx_v_o), 32'd0);
    check("rx_drop_total", 32'(drop_count_o), 32'(drop_exp));
    check("rx_drop_model", 32'(drop_exp), 32'd4);

    // Reset mid-stream with FIFO holding one packet and tx FULL
    link_send(4'd2, 4'd0, 8'h77);
    cycle();
    link_v_i = 1'b0;
    link_ready_i = 1'b0;
    host_req(2'b01, 8'h30, 8'h99);
    cycle();
    host_v_i = 1'b0;
    check("pre_rst_link_v", 32'(link_v_o), 32'd1);
    check("pre_rst_rx_v", 32'(rx_v_o), 32'd1);
    check("pre_rst_credits", 32'(out_credits_o), 32'd3);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_link_v", 32'(link_v_o), 32'd0);
    check("async_rst_rx_v", 32'(rx_v_o), 32'd0);
    check("async_rst_host_ready", 32'(host_ready_o), 32'd0);
    tx_q.delete();
    rx_q.delete();
    drop_exp = '0;
    cycle();
    reset_i = 1'b0;
    link_ready_i = 1'b1;
    #1;
    check("rerst_credits", 32'(out_credits_o), 32'd4);
    check("rerst_drop", 32'(drop_count_o), 32'd0);
    check("rerst_link_ready", 32'(link_ready_o), 32'd1);
    check("rerst_host_ready", 32'(host_ready_o), 32'd1);
    host_req(2'b00, 8'h31, 8'h11);
    cycle();
    host_v_i = 1'b0;
    cycle();
    check("rerst_tx_drained", 32'(tx_q.size()), 32'd0);
    check("rerst_tx_count", 32'(tx_count), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_edge_endpoint.md
Name: bsg_manycore_edge_endpoint

Overview:
Off-array endpoint on one edge link (one row of E/W or one column of N/S) of the manycore array. Injects host requests into the array as orig packets and receives orig packets leaving the array. Rx packets are filtered by destination coordinate and buffered for the host. Tx injection is flow-controlled by a credit counter so the host cannot flood the array.

Parameters:
addr_width_p, hdata_width_p (bsg_vscale_pkg), address field width
data_width_p, hdata_width_p, data field width
x_cord_width_p, "inv", X coordinate width; must match array x_cord_width_lp
y_cord_width_p, "inv", Y coordinate width; must match array y_cord_width_lp
max_out_credits_p, 4, outstanding-packet credits; >=1
rx_fifo_els_p, 2, rx buffer depth; >=2
orig_packet_width_lp, `bsg_manycore_orig_packet_width(addr,data,x,y), derived

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
my_x_i  in  x_cord_width_p  this endpoint's X coordinate (static)
my_y_i  in  y_cord_width_p  this endpoint's Y coordinate (static)
host_v_i  in  1  host request valid
host_op_i  in  2  request opcode
host_addr_i  in  addr_width_p  request address
host_data_i  in  data_width_p  request data
host_x_i  in  x_cord_width_p  destination X
host_y_i  in  y_cord_width_p  destination Y
host_ready_o  out  1  request accepted when host_v_i & host_ready_o
link_data_o  out  orig_packet_width_lp  packet into array edge
link_v_o  out  1  packet valid
link_ready_i  in  1  array edge ready; transfer on link_v_o & link_ready_i
link_data_i  in  orig_packet_width_lp  packet from array edge
link_v_i  in  1  packet valid
link_ready_o  out  1  rx buffer can accept
rx_v_o  out  1  buffered rx packet valid
rx_op_o / rx_addr_o / rx_data_o / rx_x_o / rx_y_o  out  field widths  decoded head packet
rx_yumi_i  in  1  host consumes head; only legal when rx_v_o
credit_i  in  1  one-cycle pulse: one credit returned
out_credits_o  out  $clog2(max_out_credits_p+1)  credits available
drop_count_o  out  16  misrouted rx packets dropped, saturating

Behaviour:
- Orig packet layout, MSB->LSB: {op[1:0], addr, data, y_cord, x_cord}; coordinates occupy the LSB x+y bits.
- Reset (async assert, sync release): link_v_o=0, rx_v_o=0, host_ready_o=0 during reset, out_credits_o=max_out_credits_p, drop_count_o=0, rx FIFO empty.
- Tx FSM, states EMPTY and FULL, one packet register:
  - EMPTY: host_ready_o = (out_credits_o != 0). Accept -> pack fields, decrement credits, go FULL.
  - FULL: link_v_o=1, link_data_o stable. On link_ready_i the packet transfers next edge. If host_v_i is also valid and credits != 0 in that cycle, host_ready_o=1: reload the register and stay FULL (full throughput). Otherwise go EMPTY.
  - Latency from host accept to link_v_o is 1 cycle.
- Credits:
  - Decrement on host accept; increment on credit_i.
  - Both in the same cycle -> unchanged.
  - credit_i with counter == max is an overflow: the counter holds and a simulation-only error fires.
  - Zero credits -> host_ready_o=0.
- Rx:
  - link_ready_o = !fifo_full; the FIFO is ready-valid with enq = link_v_i & link_ready_o.
  - If the enqueued packet's x_cord/y_cord != my_x_i/my_y_i, it is consumed but not enqueued, and drop_count_o increments, saturating at 16'hFFFF.
  - Matching packets appear on rx_v_o the cycle after enqueue (registered FIFO, no bypass).
  - Simultaneous enq and rx_yumi_i while full: link_ready_o stays 0 that cycle (no same-cycle pass-through). When neither empty nor full, both proceed.
  - Pointers wrap modulo rx_fifo_els_p.
- Reset mid-operation:
  - Any packet held in the tx register or FIFO is discarded.
  - Credits restore to max. Host and credit return source must be reset together.
- Sim assertions: rx_yumi_i without rx_v_o; credit overflow; X on link_v_i outside reset.

Decomposition:
- Shared package/header: orig packet struct and width macro (bsg_manycore_orig_packet.vh), opcode constants (store, load, config), credit counter width function.
- Sub-module: bsg_manycore_edge_rx_fifo (ready-valid FIFO with filter-drop counter). Alternatively reuse the codebase's existing two-element FIFO plus a local filter.
- Tx FSM and credit counter stay in the top.

Test Plan:
- Reset, then max_out_credits_p=4: host sends 4 packets with link_ready_i=1 -> 4 packets on consecutive cycles (addr 0x10..0x13); host_ready_o drops after the 4th. One credit_i pulse -> host_ready_o=1 next cycle.
- link_ready_i held 0 for 5 cycles with FULL tx register -> link_data_o stable and host_ready_o=0. Release -> exactly one transfer, no duplicate.
- Rx with my_x=2, my_y=0: send packets to (2,0),(3,0),(2,0) -> 2 packets on rx_v_o in order, drop_count_o=1.
- Rx FIFO full (2 entries, rx_yumi_i=0) -> link_ready_o=0. Assert rx_yumi_i -> link_ready_o=1 next cycle, and order is preserved across pointer wrap after 10 packets.
- credit_i and host accept in the same cycle at credits=1 -> out_credits_o stays 1.
- Assert reset_i mid-stream with the FIFO holding 1 and tx FULL -> link_v_o and rx_v_o drop immediately (async); after release credits=4, drop_count_o=0.
